// File: rtl/mem_xfer_seq_if.sv
// Request/response and byte-cycle signals for mem_xfer_seq.
// master = the sequencer, slave = requester plus byte-cycle unit.
interface mem_xfer_seq_if;
   logic        req;
   logic        req_wr;
   logic        req_word;
   logic        req_dec;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        ready;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        cyc_activate;
   logic [15:0] cyc_addr;
   logic        cyc_rd;
   logic        cyc_wr;
   logic [7:0]  cyc_wdata;
   logic [7:0]  cyc_rdata;
   logic        cyc_done;

   modport master (
      input  req, req_wr, req_word, req_dec, req_addr, req_wdata,
      input  cyc_rdata, cyc_done,
      output ready, rsp_valid, rsp_rdata,
      output cyc_activate, cyc_addr, cyc_rd, cyc_wr, cyc_wdata
   );

   modport slave (
      output req, req_wr, req_word, req_dec, req_addr, req_wdata,
      output cyc_rdata, cyc_done,
      input  ready, rsp_valid, rsp_rdata,
      input  cyc_activate, cyc_addr, cyc_rd, cyc_wr, cyc_wdata
   );
endinterface

// File: rtl/mem_xfer_seq.sv
// Splits an 8/16-bit memory request into byte cycles and assembles read data.
// Define MEM_XFER_DESCEND_EN to enable descending (push) byte order via req_dec.
module mem_xfer_seq (
   input  logic          clk,
   input  logic          reset,
   mem_xfer_seq_if.master bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAP} state_t;

   state_t      state_reg;
   logic        wr_reg;
   logic        word_reg;
   logic        idx_reg;
   logic        slot_hi_reg;
   logic [15:0] addr_reg;
   logic [15:0] wdata_reg;

   logic [15:0] first_addr;
   logic        first_hi;
   logic [7:0]  first_wdata;
   logic [15:0] second_addr;
   logic        second_hi;
   logic [7:0]  second_wdata;

   assign bus.ready = (state_reg == IDLE) && !reset;

`ifdef MEM_XFER_DESCEND_EN
   logic dec_reg;

   // Descending: the word lives at addr-2..addr-1, high byte fetched first.
   always_comb begin
      first_addr  = bus.req_dec ? bus.req_addr - 16'd1 : bus.req_addr;
      first_hi    = bus.req_dec & bus.req_word;
      second_addr = dec_reg ? addr_reg - 16'd2 : addr_reg + 16'd1;
      second_hi   = !dec_reg;
   end
`else
   logic unused_dec;
   assign unused_dec = bus.req_dec;

   always_comb begin
      first_addr  = bus.req_addr;
      first_hi    = 1'b0;
      second_addr = addr_reg + 16'd1;
      second_hi   = 1'b1;
   end
`endif

   assign first_wdata  = first_hi  ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
   assign second_wdata = second_hi ? wdata_reg[15:8]     : wdata_reg[7:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         wr_reg           <= 1'b0;
         word_reg         <= 1'b0;
         idx_reg          <= 1'b0;
         slot_hi_reg      <= 1'b0;
         addr_reg         <= 16'h0000;
         wdata_reg        <= 16'h0000;
`ifdef MEM_XFER_DESCEND_EN
         dec_reg          <= 1'b0;
`endif
         bus.rsp_valid    <= 1'b0;
         bus.rsp_rdata    <= 16'h0000;
         bus.cyc_activate <= 1'b0;
         bus.cyc_addr     <= 16'h0000;
         bus.cyc_rd       <= 1'b0;
         bus.cyc_wr       <= 1'b0;
         bus.cyc_wdata    <= 8'h00;
      end else begin
         bus.rsp_valid    <= 1'b0;
         bus.cyc_activate <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.req) begin
                  wr_reg           <= bus.req_wr;
                  word_reg         <= bus.req_word;
                  addr_reg         <= bus.req_addr;
                  wdata_reg        <= bus.req_wdata;
`ifdef MEM_XFER_DESCEND_EN
                  dec_reg          <= bus.req_dec;
`endif
                  idx_reg          <= 1'b0;
                  slot_hi_reg      <= first_hi;
                  bus.rsp_rdata    <= 16'h0000;
                  bus.cyc_activate <= 1'b1;
                  bus.cyc_addr     <= first_addr;
                  bus.cyc_rd       <= !bus.req_wr;
                  bus.cyc_wr       <= bus.req_wr;
                  bus.cyc_wdata    <= first_wdata;
                  state_reg        <= ISSUE;
               end
            end
            ISSUE: state_reg <= WAIT;
            WAIT: begin
               if (bus.cyc_done)
                  state_reg <= CAP;
            end
            CAP: begin
               if (!wr_reg) begin
                  if (slot_hi_reg)
                     bus.rsp_rdata[15:8] <= bus.cyc_rdata;
                  else
                     bus.rsp_rdata[7:0]  <= bus.cyc_rdata;
               end
               // Second byte re-enters ISSUE so the byte-cycle unit sees a gap.
               if (!idx_reg && word_reg) begin
                  idx_reg          <= 1'b1;
                  slot_hi_reg      <= second_hi;
                  bus.cyc_activate <= 1'b1;
                  bus.cyc_addr     <= second_addr;
                  bus.cyc_wdata    <= second_wdata;
                  state_reg        <= ISSUE;
               end else begin
                  bus.rsp_valid    <= 1'b1;
                  bus.cyc_rd       <= 1'b0;
                  bus.cyc_wr       <= 1'b0;
                  state_reg        <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_xfer_seq.sv
// Randomised self-checking bench for mem_xfer_seq with a 3-cycle byte-cycle model.
module tb_mem_xfer_seq;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_xfer_seq_if bus ();

   mem_xfer_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Byte-cycle unit model: done 3 cycles after activate, rdata = addr ^ 5A.
   logic model_done;
   logic stray_done;
   int   model_cnt;

   assign bus.cyc_done  = model_done | stray_done;
   assign bus.cyc_rdata = bus.cyc_addr[7:0] ^ 8'h5A;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_cnt  <= 0;
         model_done <= 1'b0;
      end else begin
         model_done <= 1'b0;
         if (bus.cyc_activate)
            model_cnt <= 1;
         else if (model_cnt == 2) begin
            model_done <= 1'b1;
            model_cnt  <= 0;
         end else if (model_cnt != 0)
            model_cnt <= model_cnt + 1;
      end
   end

   // Monitor: records every activated byte cycle and every response.
   int          cnt = 0;
   int          p0;
   int          act_cyc[$];
   logic [15:0] act_addr[$];
   logic [7:0]  act_wdata[$];
   logic        act_rd[$];
   logic        act_wr[$];
   int          rsp_cnt = 0;
   logic [15:0] rsp_data;
   int          rsp_cyc;

   always @(posedge clk) begin
      #1;
      cnt++;
      if (bus.cyc_activate === 1'b1) begin
         act_cyc.push_back(cnt);
         act_addr.push_back(bus.cyc_addr);
         act_wdata.push_back(bus.cyc_wdata);
         act_rd.push_back(bus.cyc_rd);
         act_wr.push_back(bus.cyc_wr);
      end
      if (bus.rsp_valid === 1'b1) begin
         rsp_cnt++;
         rsp_data = bus.rsp_rdata;
         rsp_cyc  = cnt;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Memory view: word stored little-endian at base; descending base is below addr.
   task automatic model(input logic word, input logic dec, input logic [15:0] addr,
                        input logic [15:0] wdata, output int n,
                        output logic [15:0] a0, output logic [15:0] a1,
                        output logic [7:0] d0, output logic [7:0] d1,
                        output logic [15:0] rdata);
      logic        eff_dec;
      logic [15:0] base;
      logic [15:0] lo_a;
      logic [15:0] hi_a;
`ifdef MEM_XFER_DESCEND_EN
      eff_dec = dec;
`else
      eff_dec = 1'b0;
`endif
      n    = word ? 2 : 1;
      base = eff_dec ? addr - (word ? 16'd2 : 16'd1) : addr;
      lo_a = base;
      hi_a = base + 16'd1;
      if (eff_dec && word) begin
         a0 = hi_a; d0 = wdata[15:8];
         a1 = lo_a; d1 = wdata[7:0];
      end else begin
         a0 = lo_a; d0 = wdata[7:0];
         a1 = hi_a; d1 = wdata[15:8];
      end
      rdata = word ? {hi_a[7:0] ^ 8'h5A, lo_a[7:0] ^ 8'h5A} : {8'h00, lo_a[7:0] ^ 8'h5A};
   endtask

   task automatic clear_mon();
      act_cyc.delete();
      act_addr.delete();
      act_wdata.delete();
      act_rd.delete();
      act_wr.delete();
      rsp_cnt = 0;
   endtask

   // Called at a negedge; returns at the negedge of cycle 1.
   task automatic start_req(input logic wr, input logic word, input logic dec,
                            input logic [15:0] addr, input logic [15:0] wdata);
      int guard = 0;
      while (bus.ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      clear_mon();
      bus.req       = 1'b1;
      bus.req_wr    = wr;
      bus.req_word  = word;
      bus.req_dec   = dec;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(negedge clk);
      bus.req = 1'b0;
      p0 = cnt;
   endtask

   task automatic wait_rsp(input int target);
      int guard = 0;
      while (rsp_cnt < target && guard < 200) begin
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 16'h0 ||
          bus.cyc_activate !== 1'b0 || bus.cyc_addr !== 16'h0 || bus.cyc_rd !== 1'b0 ||
          bus.cyc_wr !== 1'b0 || bus.cyc_wdata !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_values: ready=%b rsp=%b rdata=%h act=%b addr=%h rd=%b wr=%b wd=%h, required all zero",
                  bus.ready, bus.rsp_valid, bus.rsp_rdata, bus.cyc_activate, bus.cyc_addr,
                  bus.cyc_rd, bus.cyc_wr, bus.cyc_wdata);
      end
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b, required 1", bus.ready);
      end
   endtask

   task automatic test_transfers();
      logic        wr, word, dec;
      logic [15:0] addr, wdata, e_rd;
      logic [15:0] ea[2];
      logic [7:0]  ed[2];
      int          n;
      for (int t = 0; t < 34; t++) begin
         case (t)
            0: begin wr = 0; word = 0; dec = 0; addr = 16'h1234; wdata = 16'h0000; end
            1: begin wr = 1; word = 1; dec = 0; addr = 16'h4000; wdata = 16'hBEEF; end
            2: begin wr = 0; word = 1; dec = 0; addr = 16'hFFFF; wdata = 16'h0000; end
            3: begin wr = 1; word = 1; dec = 1; addr = 16'h0000; wdata = 16'h1234; end
            default: begin
               wr    = 1'($urandom_range(0, 1));
               word  = 1'($urandom_range(0, 1));
               dec   = 1'($urandom_range(0, 1));
               addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 3))
                                                   : 16'($urandom);
               wdata = 16'($urandom);
            end
         endcase
         model(word, dec, addr, wdata, n, ea[0], ea[1], ed[0], ed[1], e_rd);
         start_req(wr, word, dec, addr, wdata);
         wait_rsp(1);
         repeat (3) @(negedge clk);
         $display("[TB] xfer wr=%0d word=%0d dec=%0d addr=%h wdata=%h acts=%0d rdata=%h",
                  wr, word, dec, addr, wdata, act_addr.size(), rsp_data);
         n_tests++;
         if (act_addr.size() != n) begin
            n_fail++;
            $display("FAIL act_count: got %0d, required %0d (addr=%h)", act_addr.size(), n, addr);
         end
         for (int i = 0; i < n && i < act_addr.size(); i++) begin
            n_tests++;
            if (act_addr[i] !== ea[i] || act_rd[i] !== !wr || act_wr[i] !== wr ||
                (wr && act_wdata[i] !== ed[i]) || (act_cyc[i] - p0 + 1) != 1 + 5 * i) begin
               n_fail++;
               $display("FAIL byte%0d: got addr=%h rd=%b wr=%b wd=%h cyc=%0d, required addr=%h rd=%b wr=%b wd=%h cyc=%0d",
                        i, act_addr[i], act_rd[i], act_wr[i], act_wdata[i], act_cyc[i] - p0 + 1,
                        ea[i], !wr, wr, ed[i], 1 + 5 * i);
            end
         end
         n_tests++;
         if (rsp_cnt != 1 || (rsp_cyc - p0 + 1) != 1 + 5 * n) begin
            n_fail++;
            $display("FAIL rsp: got count=%0d cyc=%0d, required count=1 cyc=%0d",
                     rsp_cnt, rsp_cyc - p0 + 1, 1 + 5 * n);
         end
         if (!wr) begin
            n_tests++;
            if (rsp_data !== e_rd) begin
               n_fail++;
               $display("FAIL rdata: got %h, required %h (addr=%h word=%0d dec=%0d)",
                        rsp_data, e_rd, addr, word, dec);
            end
         end
      end
   endtask

   task automatic test_busy_req();
      logic [15:0] addr, e_rd, a0, a1;
      logic [7:0]  d0, d1;
      int          n;
      addr = 16'($urandom);
      model(1'b1, 1'b0, addr, 16'h0, n, a0, a1, d0, d1, e_rd);
      start_req(1'b0, 1'b1, 1'b0, addr, 16'h0);
      @(negedge clk);
      bus.req      = 1'b1;
      bus.req_wr   = 1'b1;
      bus.req_word = 1'b0;
      bus.req_addr = 16'($urandom);
      @(negedge clk);
      bus.req = 1'b0;
      wait_rsp(1);
      repeat (15) @(negedge clk);
      $display("[TB] busy_req addr=%h acts=%0d rsps=%0d rdata=%h", addr, act_addr.size(), rsp_cnt, rsp_data);
      n_tests++;
      if (act_addr.size() != 2 || rsp_cnt != 1 || rsp_data !== e_rd || act_wr.sum() != 0) begin
         n_fail++;
         $display("FAIL busy_req: got acts=%0d rsps=%0d rdata=%h, required acts=2 rsps=1 rdata=%h no writes",
                  act_addr.size(), rsp_cnt, rsp_data, e_rd);
      end
   endtask

   task automatic test_stray_done();
      logic [15:0] e_rd, a0, a1;
      logic [7:0]  d0, d1;
      int          n;
      clear_mon();
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (5) @(negedge clk);
      $display("[TB] stray_done ready=%b acts=%0d rsps=%0d", bus.ready, act_addr.size(), rsp_cnt);
      n_tests++;
      if (bus.ready !== 1'b1 || act_addr.size() != 0 || rsp_cnt != 0) begin
         n_fail++;
         $display("FAIL stray_done: got ready=%b acts=%0d rsps=%0d, required 1 0 0",
                  bus.ready, act_addr.size(), rsp_cnt);
      end
      model(1'b0, 1'b0, 16'h00C3, 16'h0, n, a0, a1, d0, d1, e_rd);
      start_req(1'b0, 1'b0, 1'b0, 16'h00C3, 16'h0);
      wait_rsp(1);
      $display("[TB] after_stray read addr=00c3 rdata=%h cyc=%0d", rsp_data, rsp_cyc - p0 + 1);
      n_tests++;
      if (rsp_cnt != 1 || rsp_data !== e_rd || (rsp_cyc - p0 + 1) != 6) begin
         n_fail++;
         $display("FAIL after_stray: got rsps=%0d rdata=%h cyc=%0d, required 1 %h 6",
                  rsp_cnt, rsp_data, rsp_cyc - p0 + 1, e_rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] e_rd, a0, a1;
      logic [7:0]  d0, d1;
      int          n;
      int          guard = 0;
      start_req(1'b1, 1'b1, 1'b0, 16'h2000, 16'hA55A);
      while (act_addr.size() < 2 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      $display("[TB] reset_mid acts=%0d ready=%b act=%b addr=%h", act_addr.size(), bus.ready,
               bus.cyc_activate, bus.cyc_addr);
      n_tests++;
      if (act_addr.size() != 2 || bus.ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          bus.rsp_rdata !== 16'h0 || bus.cyc_activate !== 1'b0 || bus.cyc_addr !== 16'h0 ||
          bus.cyc_rd !== 1'b0 || bus.cyc_wr !== 1'b0 || bus.cyc_wdata !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_mid_values: got acts=%0d ready=%b rsp=%b rdata=%h act=%b addr=%h rd=%b wr=%b wd=%h, required 2 and all zero",
                  act_addr.size(), bus.ready, bus.rsp_valid, bus.rsp_rdata, bus.cyc_activate,
                  bus.cyc_addr, bus.cyc_rd, bus.cyc_wr, bus.cyc_wdata);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      n_tests++;
      if (rsp_cnt != 0 || act_addr.size() != 2) begin
         n_fail++;
         $display("FAIL reset_mid_abort: got rsps=%0d acts=%0d, required 0 2", rsp_cnt, act_addr.size());
      end
      model(1'b0, 1'b0, 16'h0042, 16'h0, n, a0, a1, d0, d1, e_rd);
      start_req(1'b0, 1'b0, 1'b0, 16'h0042, 16'h0);
      wait_rsp(1);
      $display("[TB] post_reset read addr=0042 rdata=%h", rsp_data);
      n_tests++;
      if (rsp_cnt != 1 || rsp_data !== e_rd || act_addr.size() != 1 || act_addr[0] !== 16'h0042) begin
         n_fail++;
         $display("FAIL post_reset_read: got rsps=%0d rdata=%h acts=%0d, required 1 %h 1",
                  rsp_cnt, rsp_data, act_addr.size(), e_rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] addr1, addr2, e1, e2, a0, a1;
      logic [7:0]  d0, d1;
      int          n, c_rsp;
      int          guard = 0;
      addr1 = 16'($urandom);
      addr2 = 16'($urandom);
      model(1'b0, 1'b0, addr1, 16'h0, n, a0, a1, d0, d1, e1);
      model(1'b1, 1'b0, addr2, 16'h0, n, a0, a1, d0, d1, e2);
      start_req(1'b0, 1'b0, 1'b0, addr1, 16'h0);
      while (bus.rsp_valid !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      c_rsp = cnt;
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.ready !== 1'b1 || bus.rsp_rdata !== e1) begin
         n_fail++;
         $display("FAIL b2b_first: got rsp=%b ready=%b rdata=%h, required 1 1 %h",
                  bus.rsp_valid, bus.ready, bus.rsp_rdata, e1);
      end
      bus.req       = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_word  = 1'b1;
      bus.req_dec   = 1'b0;
      bus.req_addr  = addr2;
      @(negedge clk);
      bus.req = 1'b0;
      n_tests++;
      if (act_cyc.size() != 2 || act_cyc[act_cyc.size() - 1] != c_rsp + 1) begin
         n_fail++;
         $display("FAIL b2b_activate: got acts=%0d, required 2 with second in cycle after rsp",
                  act_cyc.size());
      end
      wait_rsp(2);
      $display("[TB] b2b addr1=%h addr2=%h acts=%0d rdata2=%h", addr1, addr2, act_addr.size(), rsp_data);
      n_tests++;
      if (rsp_cnt != 2 || rsp_data !== e2 || act_addr.size() != 3) begin
         n_fail++;
         $display("FAIL b2b_second: got rsps=%0d rdata=%h acts=%0d, required 2 %h 3",
                  rsp_cnt, rsp_data, act_addr.size(), e2);
      end
   endtask

   initial begin
      bus.req       = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_word  = 1'b0;
      bus.req_dec   = 1'b0;
      bus.req_addr  = 16'h0;
      bus.req_wdata = 16'h0;
      stray_done    = 1'b0;
      reset         = 1'b1;
      @(negedge clk);
      test_reset();
      test_transfers();
      test_busy_req();
      test_stray_done();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
